// File: rtl/uart_pkg.sv
// Shared constants and divisor type for the UART baud generator and its
// register block.
package uart_pkg;

    localparam int CNT_W      = 16;
    localparam int FRAC_W     = 4;
    localparam int OVERSAMPLE = 16;

    localparam logic [CNT_W-1:0]  DEF_INT  = 16'd54;
    localparam logic [FRAC_W-1:0] DEF_FRAC = 4'd4;
    localparam logic [CNT_W-1:0]  MIN_INT  = 16'd2;

    typedef struct packed {
        logic [CNT_W-1:0]  div_int;
        logic [FRAC_W-1:0] div_frac;
    } baud_div_t;

    // A period shorter than two clocks cannot hold the registered tick.
    function automatic logic div_valid(input logic [CNT_W-1:0] value);
        return (value >= MIN_INT);
    endfunction

endpackage

// File: rtl/uart_frac_baud_gen_if.sv
// Control and tick bundle between the baud generator and its users.
interface uart_frac_baud_gen_if;
    import uart_pkg::*;

    logic              en;
    logic              resync;
    logic [CNT_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              div_load;
    logic              div_pending;
    logic              div_err;
    logic              tick_os;
    logic              tick_mid;
    logic              tick_bit;

    modport master (
        output en, resync, div_int, div_frac, div_load,
        input  div_pending, div_err, tick_os, tick_mid, tick_bit
    );

    modport slave (
        input  en, resync, div_int, div_frac, div_load,
        output div_pending, div_err, tick_os, tick_mid, tick_bit
    );

endinterface

// File: rtl/uart_frac_accum.sv
// Fractional phase accumulator: carry stretches the current period by one clk,
// the accumulator advances once per completed period.
module uart_frac_accum
    import uart_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              adv,
    input  logic [FRAC_W-1:0] frac,
    output logic              carry
);

    logic [FRAC_W-1:0] acc_r;
    logic [FRAC_W:0]   sum_s;

    // Sum of the running phase and the fractional step.
    always_comb begin
        sum_s = {1'b0, acc_r} + {1'b0, frac};
    end

    assign carry = sum_s[FRAC_W];

    // Phase register; clear restarts from zero so the first period is un-stretched.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r <= {FRAC_W{1'b0}};
        end else if (clear) begin
            acc_r <= {FRAC_W{1'b0}};
        end else if (adv) begin
            acc_r <= sum_s[FRAC_W-1:0];
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule

// File: rtl/uart_frac_baud_gen.sv
// Runtime-programmable fractional baud generator producing oversample,
// mid-bit and bit-rate ticks.
module uart_frac_baud_gen #(
    parameter int                           OVERSAMPLE = uart_pkg::OVERSAMPLE,
    parameter logic [uart_pkg::CNT_W-1:0]   DEF_INT    = uart_pkg::DEF_INT,
    parameter logic [uart_pkg::FRAC_W-1:0]  DEF_FRAC   = uart_pkg::DEF_FRAC
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_frac_baud_gen_if.slave  bus
);
    import uart_pkg::*;

    localparam int             OS_W    = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_ONE  = OS_W'(1);
    localparam baud_div_t       DEF_DIV = '{div_int: DEF_INT, div_frac: DEF_FRAC};

    logic [CNT_W:0]  cnt_r;
    logic [OS_W-1:0] os_cnt_r;
    logic            tick_os_r;
    logic            tick_mid_r;
    logic            tick_bit_r;
    baud_div_t       active_r;
    baud_div_t       shadow_r;
    logic            pending_r;
    logic            err_r;

    baud_div_t       active_nx;
    baud_div_t       shadow_nx;
    logic            pending_nx;
    logic            err_nx;
    baud_div_t       load_div_s;
    logic            load_ok_s;
    logic            carry_s;
    logic [CNT_W:0]  period_last_s;
    logic            period_end_s;

    uart_frac_accum u_accum (
        .clk   (clk),
        .reset (reset),
        .clear (bus.resync),
        .adv   (period_end_s),
        .frac  (active_r.div_frac),
        .carry (carry_s)
    );

    // Last count of the current period; cnt is one bit wider so P may reach 2^CNT_W.
    always_comb begin
        period_last_s = {1'b0, active_r.div_int} + {{CNT_W{1'b0}}, carry_s}
                        - {{CNT_W{1'b0}}, 1'b1};
        period_end_s  = bus.en && (cnt_r == period_last_s);
        load_div_s    = '{div_int: bus.div_int, div_frac: bus.div_frac};
        load_ok_s     = div_valid(bus.div_int);
    end

    // Divisor bookkeeping; a load together with resync takes effect immediately.
    always_comb begin
        active_nx  = active_r;
        shadow_nx  = shadow_r;
        pending_nx = pending_r;
        err_nx     = err_r;
        if (bus.resync) begin
            pending_nx = 1'b0;
            if (pending_r) begin
                active_nx = shadow_r;
            end else begin
                active_nx = active_r;
            end
            if (bus.div_load) begin
                if (load_ok_s) begin
                    active_nx = load_div_s;
                    shadow_nx = load_div_s;
                    err_nx    = 1'b0;
                end else begin
                    err_nx    = 1'b1;
                end
            end else begin
                err_nx = err_r;
            end
        end else begin
            if (period_end_s && pending_r) begin
                active_nx  = shadow_r;
                pending_nx = 1'b0;
            end else begin
                active_nx  = active_r;
            end
            if (bus.div_load) begin
                if (load_ok_s) begin
                    shadow_nx  = load_div_s;
                    pending_nx = 1'b1;
                    err_nx     = 1'b0;
                end else begin
                    err_nx     = 1'b1;
                end
            end else begin
                shadow_nx = shadow_r;
            end
        end
    end

    // Divisor state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_r  <= DEF_DIV;
            shadow_r  <= DEF_DIV;
            pending_r <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            active_r  <= active_nx;
            shadow_r  <= shadow_nx;
            pending_r <= pending_nx;
            err_r     <= err_nx;
        end
    end

    // Period and oversample counters with registered tick generation.
    always_ff @(posedge clk) begin
        if (reset || bus.resync) begin
            cnt_r      <= {(CNT_W+1){1'b0}};
            os_cnt_r   <= {OS_W{1'b0}};
            tick_os_r  <= 1'b0;
            tick_mid_r <= 1'b0;
            tick_bit_r <= 1'b0;
        end else if (period_end_s) begin
            cnt_r      <= {(CNT_W+1){1'b0}};
            tick_os_r  <= 1'b1;
            tick_mid_r <= (os_cnt_r == OS_MID);
            tick_bit_r <= (os_cnt_r == OS_LAST);
            if (os_cnt_r == OS_LAST) begin
                os_cnt_r <= {OS_W{1'b0}};
            end else begin
                os_cnt_r <= os_cnt_r + OS_ONE;
            end
        end else begin
            if (bus.en) begin
                cnt_r <= cnt_r + {{CNT_W{1'b0}}, 1'b1};
            end else begin
                cnt_r <= cnt_r;
            end
            tick_os_r  <= 1'b0;
            tick_mid_r <= 1'b0;
            tick_bit_r <= 1'b0;
        end
    end

    assign bus.tick_os     = tick_os_r;
    assign bus.tick_mid    = tick_mid_r;
    assign bus.tick_bit    = tick_bit_r;
    assign bus.div_pending = pending_r;
    assign bus.div_err     = err_r;

endmodule

// File: tb/tb_uart_frac_baud_gen.sv
// Directed self-checking bench for uart_frac_baud_gen: tick intervals,
// fractional patterns, divisor loading, enable gating, resync and reset.
module tb_uart_frac_baud_gen;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    uart_frac_baud_gen_if bus ();

    uart_frac_baud_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Edges until the next tick_os; -1 when the bound expires.
    task automatic wait_tick(output int n, output logic mid, output logic bt);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.tick_os && n < 200);
        mid = bus.tick_mid;
        bt  = bus.tick_bit;
        if (!bus.tick_os) n = -1;
    endtask

    task automatic pulse(input logic rs, input logic ld, input logic [15:0] di, input logic [3:0] df);
        bus.resync   = rs;
        bus.div_load = ld;
        bus.div_int  = di;
        bus.div_frac = df;
        @(posedge clk);
        #1;
        bus.resync   = 1'b0;
        bus.div_load = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n, sum, midx, bidx, mids, bits;
        logic m, b;

        reset        = 1'b1;
        bus.en       = 1'b1;
        bus.resync   = 1'b0;
        bus.div_load = 1'b0;
        bus.div_int  = 16'd0;
        bus.div_frac = 4'd0;
        step(3);
        check_val("rst_tick_os",  32'(bus.tick_os),     32'd0);
        check_val("rst_tick_mid", 32'(bus.tick_mid),    32'd0);
        check_val("rst_tick_bit", 32'(bus.tick_bit),    32'd0);
        check_val("rst_pending",  32'(bus.div_pending), 32'd0);
        check_val("rst_err",      32'(bus.div_err),     32'd0);

        // Defaults 54 + 0.25: 54,54,54,55 repeating; mid on 8th, bit on 16th tick.
        reset = 1'b0;
        sum = 0; midx = 0; bidx = 0;
        for (int i = 1; i <= 16; i++) begin
            wait_tick(n, m, b);
            if (i <= 4) check_val("def_interval", 32'(n), (i == 4) ? 32'd55 : 32'd54);
            sum += n;
            if (m && midx == 0) midx = i;
            if (b && bidx == 0) bidx = i;
        end
        check_val("def_sum16", 32'(sum), 32'd868);
        check_val("def_mid_idx", 32'(midx), 32'd8);
        check_val("def_bit_idx", 32'(bidx), 32'd16);

        // Integer divisor 4 loaded with resync: bit tick lands at cycle 64.
        pulse(1'b1, 1'b1, 16'd4, 4'd0);
        sum = 0; midx = 0; bidx = 0; mids = 0; bits = 0;
        for (int i = 1; i <= 16; i++) begin
            wait_tick(n, m, b);
            sum += n;
            if (m) begin mids++; midx = i; end
            if (b) begin bits++; bidx = i; end
        end
        check_val("int4_cycle64", 32'(sum), 32'd64);
        check_val("int4_mid_idx", 32'(midx), 32'd8);
        check_val("int4_bit_idx", 32'(bidx), 32'd16);
        check_val("int4_mid_cnt", 32'(mids), 32'd1);
        check_val("int4_bit_cnt", 32'(bits), 32'd1);

        // 4.5 divisor: strict 4/5 alternation, 32 intervals total 144.
        pulse(1'b1, 1'b1, 16'd4, 4'd8);
        sum = 0;
        for (int i = 0; i < 32; i++) begin
            wait_tick(n, m, b);
            check_val("frac_interval", 32'(n), (i % 2 == 0) ? 32'd4 : 32'd5);
            sum += n;
        end
        check_val("frac_sum32", 32'(sum), 32'd144);

        // Load 10 mid-period under divisor 54: pending until the period ends.
        pulse(1'b1, 1'b1, 16'd54, 4'd0);
        step(20);
        pulse(1'b0, 1'b1, 16'd10, 4'd0);
        check_val("load_pending", 32'(bus.div_pending), 32'd1);
        wait_tick(n, m, b);
        check_val("load_old_period", 32'(n), 32'd33);
        check_val("load_pending_drop", 32'(bus.div_pending), 32'd0);
        wait_tick(n, m, b);
        check_val("load_new_period", 32'(n), 32'd10);

        // Rejected load: error set, no pending, period unchanged.
        pulse(1'b0, 1'b1, 16'd1, 4'd0);
        check_val("bad_err", 32'(bus.div_err), 32'd1);
        check_val("bad_pending", 32'(bus.div_pending), 32'd0);
        wait_tick(n, m, b);
        check_val("bad_period", 32'(n + 1), 32'd10);
        wait_tick(n, m, b);
        check_val("bad_period2", 32'(n), 32'd10);
        pulse(1'b0, 1'b1, 16'd10, 4'd0);
        check_val("good_err_clr", 32'(bus.div_err), 32'd0);
        check_val("good_pending", 32'(bus.div_pending), 32'd1);
        wait_tick(n, m, b);
        check_val("good_period", 32'(n + 1), 32'd10);
        check_val("good_pending_drop", 32'(bus.div_pending), 32'd0);

        // Enable low for 7 cycles mid-period stretches that period by 7.
        step(3);
        bus.en = 1'b0;
        step(7);
        check_val("en_hold_no_tick", 32'(bus.tick_os), 32'd0);
        bus.en = 1'b1;
        wait_tick(n, m, b);
        check_val("en_gap_period", 32'(n + 10), 32'd17);

        // Resync on the very edge a tick was due, with os_cnt at 5.
        pulse(1'b1, 1'b0, 16'd0, 4'd0);
        for (int i = 0; i < 5; i++) wait_tick(n, m, b);
        step(8);
        pulse(1'b1, 1'b0, 16'd0, 4'd0);
        check_val("resync_no_tick", 32'(bus.tick_os), 32'd0);
        midx = 0;
        for (int i = 1; i <= 8; i++) begin
            wait_tick(n, m, b);
            if (i == 1) check_val("resync_period", 32'(n), 32'd10);
            if (m && midx == 0) midx = i;
        end
        check_val("resync_mid_idx", 32'(midx), 32'd8);

        // Reset mid-period with a pending load: everything returns to defaults.
        step(5);
        pulse(1'b0, 1'b1, 16'd20, 4'd0);
        reset = 1'b1;
        step(1);
        check_val("mid_rst_pending", 32'(bus.div_pending), 32'd0);
        check_val("mid_rst_tick", 32'(bus.tick_os), 32'd0);
        reset = 1'b0;
        wait_tick(n, m, b);
        check_val("mid_rst_period", 32'(n), 32'd54);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
